// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its busy scoreboard.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int AW       = $clog2(NREG);
  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits. An issue sets a bit and a writeback clears it.
// If both hit the same register on one edge, the issue wins.
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic          we,
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);
  import regfile_pkg::*;

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            wb_clear;
  logic            issue_set;

  assign wb_clear  = we && (rd_addr != ZERO_IDX);
  assign issue_set = issue_valid && (issue_rd != ZERO_IDX);

  // The clear is applied first so that a same-register issue overrides it.
  always_comb begin
    busy_next = busy;
    if (wb_clear)  busy_next[rd_addr]  = 1'b0;
    if (issue_set) busy_next[issue_rd] = 1'b1;
    busy_next[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // A writeback in flight this cycle already counts as having produced the value.
  assign rs1_busy = busy[rs1_addr] && !(we && (rd_addr == rs1_addr));
  assign rs2_busy = busy[rs2_addr] && !(we && (rd_addr == rs2_addr));

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: two bypassed combinational reads, one write port,
// hardwired x0, a busy scoreboard for hazard stalls, and a single-register tap.
module regfile_sb #(
  parameter  int XLEN    = regfile_pkg::XLEN,
  parameter  int NREG    = regfile_pkg::NREG,
  parameter  int TAP_REG = regfile_pkg::REG_A0,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] wd,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [XLEN-1:0] tap_data
);
  import regfile_pkg::*;

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);
  localparam logic [AW-1:0] TAP_IDX  = AW'(TAP_REG);

  logic [XLEN-1:0] regs [NREG];

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (rd_addr != ZERO_IDX)) begin
      regs[rd_addr] <= wd;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (we && (rd_addr == rs1_addr)) rs1_data = wd;
    if (rs1_addr == ZERO_IDX)        rs1_data = '0;
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (we && (rd_addr == rs2_addr)) rs2_data = wd;
    if (rs2_addr == ZERO_IDX)        rs2_data = '0;
  end

  // The tap shows committed state only, so a write appears on it one cycle late.
  assign tap_data = regs[TAP_IDX];

  reg_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .we          (we),
    .rd_addr     (rd_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default 32x32 instance and a 16x64 instance.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, issue_rd;
  logic [31:0] rs1_data, rs2_data, wd, tap_data;
  logic        we, issue_valid, rs1_busy, rs2_busy;

  logic [3:0]  p_rs1_addr, p_rs2_addr, p_rd_addr, p_issue_rd;
  logic [63:0] p_rs1_data, p_rs2_data, p_wd, p_tap_data;
  logic        p_we, p_issue_valid, p_rs1_busy, p_rs2_busy;

  int checks;
  int failures;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .we(we), .rd_addr(rd_addr), .wd(wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .tap_data(tap_data)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .TAP_REG(3)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(p_rs1_addr), .rs2_addr(p_rs2_addr),
    .rs1_data(p_rs1_data), .rs2_data(p_rs2_data),
    .we(p_we), .rd_addr(p_rd_addr), .wd(p_wd),
    .issue_valid(p_issue_valid), .issue_rd(p_issue_rd),
    .rs1_busy(p_rs1_busy), .rs2_busy(p_rs2_busy),
    .tap_data(p_tap_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0; issue_rd = '0;
    wd = '0; we = 1'b0; issue_valid = 1'b0;
    p_rs1_addr = '0; p_rs2_addr = '0; p_rd_addr = '0; p_issue_rd = '0;
    p_wd = '0; p_we = 1'b0; p_issue_valid = 1'b0;
    #3;

    // Reset state across all addresses
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("rst_rs1_data_%0d", i), 64'(rs1_data), 64'h0);
      chk($sformatf("rst_rs2_data_%0d", i), 64'(rs2_data), 64'h0);
      chk($sformatf("rst_busy_%0d", i), {62'h0, rs1_busy, rs2_busy}, 64'h0);
    end
    chk("rst_tap", 64'(tap_data), 64'h0);
    chk("rst_tap64", p_tap_data, 64'h0);
    tick();
    rst_n = 1'b1;

    // Reset held across a write edge must win over the write
    we = 1'b1; rd_addr = 5'd3; wd = 32'h5555_5555;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    we = 1'b0; rs1_addr = 5'd3;
    #1;
    chk("rst_over_write", 64'(rs1_data), 64'h0);

    // Write-first bypass then storage readback
    tick();
    we = 1'b1; rd_addr = 5'd5; wd = 32'hDEAD_BEEF; rs1_addr = 5'd5;
    #1;
    chk("x5_bypass", 64'(rs1_data), 64'hDEAD_BEEF);
    tick();
    we = 1'b0;
    #1;
    chk("x5_stored", 64'(rs1_data), 64'hDEAD_BEEF);

    // Writes to x0 are dropped and never bypassed
    we = 1'b1; rd_addr = 5'd0; wd = 32'h0000_1234; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    chk("x0_bypass_rs1", 64'(rs1_data), 64'h0);
    chk("x0_bypass_rs2", 64'(rs2_data), 64'h0);
    tick();
    we = 1'b0;
    #1;
    chk("x0_stored", 64'(rs1_data), 64'h0);

    // Tap lags the write by one cycle; port 2 bypasses
    we = 1'b1; rd_addr = 5'd10; wd = 32'h0000_0042; rs2_addr = 5'd10;
    #1;
    chk("x10_rs2_bypass", 64'(rs2_data), 64'h42);
    chk("tap_write_cycle", 64'(tap_data), 64'h0);
    tick();
    we = 1'b0;
    #1;
    chk("tap_next_cycle", 64'(tap_data), 64'h42);
    chk("x10_rs2_stored", 64'(rs2_data), 64'h42);

    // Issue sets busy from the next cycle
    issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd8;
    #1;
    chk("busy7_issue_cycle", 64'(rs1_busy), 64'h0);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("busy7_set", 64'(rs1_busy), 64'h1);
    chk("busy8_clear", 64'(rs2_busy), 64'h0);

    // Writeback clears busy in the same cycle and in storage
    we = 1'b1; rd_addr = 5'd7; wd = 32'h0000_0077;
    #1;
    chk("busy7_wb_bypass", 64'(rs1_busy), 64'h0);
    chk("x7_wb_data", 64'(rs1_data), 64'h77);
    tick();
    we = 1'b0;
    #1;
    chk("busy7_cleared", 64'(rs1_busy), 64'h0);
    chk("x7_stored", 64'(rs1_data), 64'h77);

    // Same-register issue and writeback on one edge: set wins
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd7;
    we = 1'b1; rd_addr = 5'd7; wd = 32'h0000_ABCD;
    tick();
    issue_valid = 1'b0; we = 1'b0;
    #1;
    chk("busy7_set_wins", 64'(rs1_busy), 64'h1);
    chk("x7_set_wins_data", 64'(rs1_data), 64'hABCD);

    // Different registers on one edge: both take effect
    issue_valid = 1'b1; issue_rd = 5'd9;
    we = 1'b1; rd_addr = 5'd7; wd = 32'h0000_0001;
    rs2_addr = 5'd9;
    tick();
    issue_valid = 1'b0; we = 1'b0;
    #1;
    chk("busy7_diff_clear", 64'(rs1_busy), 64'h0);
    chk("busy9_diff_set", 64'(rs2_busy), 64'h1);

    // Issue to x0 leaves busy(0) clear
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0; rs1_addr = 5'd0;
    #1;
    chk("busy0_issue", 64'(rs1_busy), 64'h0);

    // Asynchronous reset mid-operation clears data and busy
    rs1_addr = 5'd5;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_x5", 64'(rs1_data), 64'h0);
    chk("rst_async_busy9", 64'(rs2_busy), 64'h0);
    chk("rst_async_tap", 64'(tap_data), 64'h0);
    tick();
    rst_n = 1'b1;

    // 64-bit, 16-entry instance
    tick();
    p_we = 1'b1; p_rd_addr = 4'd15; p_wd = 64'hFFFF_FFFF_0000_0001;
    tick();
    p_we = 1'b0; p_rs1_addr = 4'd15; p_rs2_addr = 4'd0;
    #1;
    chk("p_x15_read", p_rs1_data, 64'hFFFF_FFFF_0000_0001);
    chk("p_x0_read", p_rs2_data, 64'h0);
    p_we = 1'b1; p_rd_addr = 4'd3; p_wd = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("p_tap_write_cycle", p_tap_data, 64'h0);
    tick();
    p_we = 1'b0;
    #1;
    chk("p_tap_next_cycle", p_tap_data, 64'h1234_5678_9ABC_DEF0);
    p_issue_valid = 1'b1; p_issue_rd = 4'd12; p_rs1_addr = 4'd12;
    tick();
    p_issue_valid = 1'b0;
    #1;
    chk("p_busy12_set", 64'(p_rs1_busy), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the single-cycle/pipelined RISC-V core, replacing the fixed 32×32 register file in the decode stage. It provides:
- two combinational read ports and one synchronous write port;
- x0 hardwired to zero and asynchronous reset of all registers;
- write-first bypass to the read ports;
- a per-register busy scoreboard, so the hazard unit can stall on registers whose in-flight producer has not yet written back;
- a tap of one architectural register (a0 by default) for the testbench and top-level output.

## Interface
Parameters:
- XLEN, 32, data width of every register
- NREG, 32, number of architectural registers (power of two, ≥2)
- TAP_REG, 10, index of the register driven onto tap_data
- AW, $clog2(NREG), address width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  XLEN  read port 1 data
- rs2_data  out  XLEN  read port 2 data
- we  in  1  write enable
- rd_addr  in  AW  write address
- wd  in  XLEN  write data
- issue_valid  in  1  an instruction writing issue_rd is issued this cycle
- issue_rd  in  AW  destination register of the issuing instruction
- rs1_busy  out  1  rs1_addr has an outstanding producer
- rs2_busy  out  1  rs2_addr has an outstanding producer
- tap_data  out  XLEN  registered contents of register TAP_REG

## Operation
- Storage: NREG×XLEN flops.
- Reset (rst_n=0, asynchronous): every register is cleared to 0 and every busy bit to 0.
- Reads: combinational.
  - Address 0 always returns 0.
  - Otherwise, if we=1 and rd_addr equals the read address, the port returns wd (write-first bypass).
  - Otherwise the port returns the stored value.
- Write: on the rising clk edge with we=1 and rd_addr≠0, reg[rd_addr] ← wd. Writes to x0 are dropped. No other register changes.
- Scoreboard (one busy bit per register; bit 0 is constant 0):
  - Edge with issue_valid=1 and issue_rd≠0 sets busy[issue_rd].
  - Edge with we=1 and rd_addr≠0 clears busy[rd_addr].
  - Set and clear on the same register in the same cycle: set wins. The writeback belongs to an older producer and the newly issued one is still outstanding.
  - Set and clear on different registers in the same cycle: both take effect.
- Busy outputs: rsN_busy = busy[rsN_addr] AND NOT (we AND rd_addr==rsN_addr).
  - The clearing writeback is visible in the same cycle, consistent with the data bypass.
  - Address 0 always gives busy=0.
- Tap: tap_data = reg[TAP_REG], with no bypass. A write to TAP_REG appears on tap_data the cycle after the write edge.
- Issuing to a register that is already busy is legal; the bit stays set. There is no counting of multiple outstanding producers.

## Timing
- Read latency: 0 cycles, combinational from rs*_addr, we, rd_addr and wd.
- Write latency: 1 edge. The value is readable from storage in the cycle after the edge, and via bypass in the same cycle.
- Busy set: visible on rs*_busy from the cycle after the issue edge.
- Busy clear: visible on rs*_busy in the same cycle as we (via bypass), and from storage after the edge.
- Reset values: rs*_data=0 and rs*_busy=0 for any address; tap_data=0.
- Reset asserted mid-operation overrides any write or issue in that cycle. The first edge after rst_n rises behaves normally.
- No multicycle paths; the full combinational read path must close within one clk period at XLEN=32, NREG=32.

## Structure
- Package regfile_pkg:
  - constants XLEN, NREG and REG_A0=10 (REG_A0 is the TAP_REG default);
  - typedefs reg_addr_t (logic [AW-1:0]) and word_t (logic [XLEN-1:0]);
  - localparam REG_ZERO=0.
- Sub-module reg_scoreboard (NREG, AW):
  - holds the busy vector and the set-wins update;
  - provides the combinational bypassed busy lookup for two addresses.
- The data array, bypass muxes and tap stay in regfile_sb.

## Test plan
- Reset, then read all 32 addresses: rs1_data=rs2_data=0, rs*_busy=0, tap_data=0. Assert rst_n=0 mid-write: the register stays 0.
- Write x5=0xDEADBEEF with rs1_addr=5 in the same cycle: rs1_data=0xDEADBEEF via bypass. Next cycle with we=0: still 0xDEADBEEF. Write x0=0x1234: reads of x0 return 0.
- Write x10=0x00000042: tap_data stays 0 in the write cycle and reads 0x42 the following cycle. rs2_addr=10 in the write cycle shows 0x42.
- issue_valid with issue_rd=7: rs1_busy for addr 7 goes 1 the next cycle. we with rd_addr=7 clears it in the same cycle (rs1_busy=0) and the bit is 0 after the edge.
- Same edge: issue_rd=7 and we with rd_addr=7 (x7 busy beforehand): after the edge rs1_busy(7)=1 and x7 holds the written value. Issue with issue_rd=0: busy(0) stays 0.
- Re-parametrise NREG=16, XLEN=64, TAP_REG=3: write x15=0xFFFF_FFFF_0000_0001 → readback matches. Write x3 → tap_data follows one cycle later.
